dfe_sequencer: RTL

Control block for the digital front end (PDM mic -> integrator -> comb -> decimation). It generates the PDM microphone clock and samples the mic bit. It emits the single-cycle sample strobe that drives the integrator/comb `valid_i` inputs, and gates their `en_i`. It suppresses decimated outputs during the warm-up period, while the comb delay line and integrator fill, then issues one decimation strobe per window.

---
 rtl/dfe_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dfe_sequencer.sv
// Digital front-end sequencer: PDM clock generation, mic bit capture, sample strobe,
// warm-up suppression and one decimation strobe per comb window.
module dfe_sequencer #(
    parameter int CLK_DIV        = 8,
    parameter int WINDOW_LEN     = 250,
    parameter int WARMUP_WINDOWS = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       pdm_data_i,
    output logic       pdm_clk_o,
    output logic       sample_data_o,
    output logic       sample_valid_o,
    output logic       dfe_en_o,
    output logic       dec_valid_o,
    output logic [1:0] state_o
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WIN_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int WARM_W = $clog2(WARMUP_WINDOWS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_LEN - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
    logic [WIN_W-1:0]   win_cnt_r, win_cnt_s;
    logic [WARM_W-1:0]  warm_cnt_r, warm_cnt_s;
    logic               pdm_clk_r, pdm_clk_s;
    logic               sample_data_r, sample_data_s;
    logic               sample_valid_r, sample_valid_s;
    logic               dfe_en_r, dfe_en_s;
    logic               dec_valid_r, dec_valid_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_s        = ST_IDLE;
        div_cnt_s      = {DIV_W{1'b0}};
        win_cnt_s      = {WIN_W{1'b0}};
        warm_cnt_s     = {WARM_W{1'b0}};
        pdm_clk_s      = 1'b0;
        sample_data_s  = sample_data_r;
        sample_valid_s = 1'b0;
        dfe_en_s       = 1'b0;
        dec_valid_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_i) begin
                    // div_cnt restarts at 0, which is the first high phase of the PDM clock
                    state_s   = ST_WARMUP;
                    dfe_en_s  = 1'b1;
                    pdm_clk_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WARMUP, ST_RUN: begin
                if (en_i) begin
                    dfe_en_s   = 1'b1;
                    win_cnt_s  = win_cnt_r;
                    warm_cnt_s = warm_cnt_r;
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_s = {DIV_W{1'b0}};
                    end else begin
                        div_cnt_s = div_cnt_r + DIV_W'(1);
                    end
                    pdm_clk_s = (div_cnt_s < DIV_HALF);
                    // Leave warm-up on the cycle after the last warm-up strobe
                    if ((state_r == ST_WARMUP) && sample_valid_r && (warm_cnt_r == WARM_DONE)) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = state_r;
                    end
                    if (div_cnt_r == DIV_LAST) begin
                        sample_data_s  = pdm_data_i;
                        sample_valid_s = 1'b1;
                        if (win_cnt_r == WIN_LAST) begin
                            win_cnt_s   = {WIN_W{1'b0}};
                            dec_valid_s = (state_r == ST_RUN);
                            if (state_r == ST_WARMUP) begin
                                warm_cnt_s = warm_cnt_r + WARM_W'(1);
                            end else begin
                                warm_cnt_s = warm_cnt_r;
                            end
                        end else begin
                            win_cnt_s = win_cnt_r + WIN_W'(1);
                        end
                    end else begin
                        sample_valid_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            div_cnt_r      <= {DIV_W{1'b0}};
            win_cnt_r      <= {WIN_W{1'b0}};
            warm_cnt_r     <= {WARM_W{1'b0}};
            pdm_clk_r      <= 1'b0;
            sample_data_r  <= 1'b0;
            sample_valid_r <= 1'b0;
            dfe_en_r       <= 1'b0;
            dec_valid_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            div_cnt_r      <= div_cnt_s;
            win_cnt_r      <= win_cnt_s;
            warm_cnt_r     <= warm_cnt_s;
            pdm_clk_r      <= pdm_clk_s;
            sample_data_r  <= sample_data_s;
            sample_valid_r <= sample_valid_s;
            dfe_en_r       <= dfe_en_s;
            dec_valid_r    <= dec_valid_s;
        end
    end

    assign pdm_clk_o      = pdm_clk_r;
    assign sample_data_o  = sample_data_r;
    assign sample_valid_o = sample_valid_r;
    assign dfe_en_o       = dfe_en_r;
    assign dec_valid_o    = dec_valid_r;
    assign state_o        = state_r;

endmodule
